// File: rtl/arduino_cmd_receiver.sv
// arduino_cmd_receiver: synchronises the Arduino serial link, validates controller bytes and queues Tetris commands.
module arduino_cmd_receiver #(
  parameter int DEPTH       = 4,
  parameter int TIMEOUT     = 64,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       arduinoClock,
  input  logic       arduinoData,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [2:0] cmd_code,
  output logic       start_pulse,
  output logic       overflow,
  output logic [7:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int IW = $clog2(TIMEOUT + 1);
  logic [SYNC_STAGES-1:0] sclk, sdat;
  logic                   clk_prev, rise, stale, frame_done, valid, push_req, push, pop, empty, full;
  logic [2:0]             bit_cnt;
  logic [7:0]             shreg, frame;
  logic [IW-1:0]          idle;
  logic [2:0]             mem [DEPTH];
  logic [AW:0]            wr, rd, rd_n;
  always_comb begin
    rise        = sclk[SYNC_STAGES-1] & ~clk_prev;
    stale       = (idle == IW'(TIMEOUT)) && (bit_cnt != 3'd0);
    valid       = (frame[7:4] == 4'hA) && ^frame[3:0];
    push_req    = frame_done && valid && (frame[2:0] != 3'd0);
    start_pulse = frame_done && valid && (frame[2:0] == 3'd7);
    empty       = wr == rd;
    full        = (wr[AW] != rd[AW]) && (wr[AW-1:0] == rd[AW-1:0]);
    cmd_valid   = !empty;
    pop         = !empty && cmd_ready;
    push        = push_req && (!full || pop);
    rd_n        = rd + (AW+1)'(pop);
  end
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      sclk       <= '0;
      sdat       <= '0;
      clk_prev   <= 1'b0;
      bit_cnt    <= 3'd0;
      shreg      <= 8'd0;
      frame      <= 8'd0;
      frame_done <= 1'b0;
      idle       <= '0;
    end else begin
      sclk       <= SYNC_STAGES'({sclk, arduinoClock});
      sdat       <= SYNC_STAGES'({sdat, arduinoData});
      clk_prev   <= sclk[SYNC_STAGES-1];
      frame_done <= rise && (bit_cnt == 3'd7);
      idle       <= rise ? '0 : (idle == IW'(TIMEOUT)) ? idle : idle + 1'b1;
      if (rise) begin
        shreg   <= {shreg[6:0], sdat[SYNC_STAGES-1]};
        bit_cnt <= bit_cnt + 3'd1;
        if (bit_cnt == 3'd7) frame <= {shreg[6:0], sdat[SYNC_STAGES-1]};
      end else if (stale) begin
        shreg   <= 8'd0;
        bit_cnt <= 3'd0;
      end
    end
  always_ff @(posedge clock)
    if (push) mem[wr[AW-1:0]] <= frame[2:0];
  // The head register looks ahead to the entry that becomes head after this cycle's pop/push.
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      wr        <= '0;
      rd        <= '0;
      cmd_code  <= 3'd0;
      overflow  <= 1'b0;
      err_count <= 8'd0;
    end else begin
      wr <= wr + (AW+1)'(push);
      rd <= rd_n;
      if (push && rd_n == wr) cmd_code <= frame[2:0];
      else if (rd_n != wr) cmd_code <= mem[rd_n[AW-1:0]];
      if (push_req && !push) overflow <= 1'b1;
      if (frame_done && !valid && err_count != 8'hFF) err_count <= err_count + 8'd1;
    end
endmodule
